// File: rtl/credit_receiver_pkg.sv
// Shared types and elaboration helpers for the buffered credit receiver.
// Link state enum, credit-count width and the initial-credit saturation rule.
package credit_receiver_pkg;

  typedef enum logic {
    LINK_RESET = 1'b0,
    LINK_RUN   = 1'b1
  } link_state_e;

  // Bits needed to hold any count from 0 to depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int min_credit(input int req, input int cap);
    return (req > cap) ? cap : req;
  endfunction

endpackage

// File: rtl/credit_receiver_fifo_mem.sv
// DEPTH x WIDTH register FIFO with wrapping pointers (any DEPTH >= 1) and an occupancy count.
// Flush empties it at the next edge; head data is read straight from storage.
module credit_receiver_fifo_mem
  import credit_receiver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = credit_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    occupancy,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full      = (count == FULL_CNT);
  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_en && (count != '0);
  assign occupancy = count;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale words are never visible because count gates validity.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/credit_receiver_buffered.sv
// Credit-protocol receiver with a DEPTH-entry FIFO: tracks credits held by the sender,
// returns at most one credit per cycle as slots free, and flags pushes made without credit.
module credit_receiver_buffered
  import credit_receiver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = credit_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_sender_in_reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_credit_stall,
  input  logic [CW-1:0]    credit_initial,
  input  logic [CW-1:0]    credit_withhold,
  input  logic             pop_ready,
  output logic             push_credit,
  output logic             push_receiver_in_reset,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    occupancy,
  output logic             credit_overflow
);

  localparam int CW1 = CW + 1;
  localparam logic [CW1-1:0] DEPTH_X = CW1'(DEPTH);

  link_state_e    state_q;
  link_state_e    state_d;
  logic [CW-1:0]  outstanding_q;
  logic [CW-1:0]  outstanding_eff;
  logic [CW-1:0]  init_sat;
  logic [CW1-1:0] free_slots;
  logic [CW1-1:0] committed;
  logic           issue;
  logic           push_accept;
  logic           pop_fire;
  logic           fifo_full;

  // Reset handshake: in LINK_RESET until the first edge with the sender out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LINK_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LINK_RESET: if (!push_sender_in_reset) state_d = LINK_RUN;
      LINK_RUN:   if (push_sender_in_reset)  state_d = LINK_RESET;
      default:    state_d = LINK_RESET;
    endcase
  end

  assign push_receiver_in_reset = (state_q == LINK_RESET);

  // While held in reset the sender's credit count tracks the (saturated) initial grant.
  assign init_sat        = CW'(min_credit(int'(credit_initial), DEPTH));
  assign outstanding_eff = push_receiver_in_reset ? init_sat : outstanding_q;

  assign free_slots  = DEPTH_X - {1'b0, occupancy};
  assign committed   = {1'b0, outstanding_eff} + {1'b0, credit_withhold};
  assign issue       = !push_sender_in_reset && !push_credit_stall && (free_slots > committed);
  assign push_accept = push_valid && !push_sender_in_reset && (outstanding_eff != '0) && !fifo_full;
  assign pop_fire    = pop_valid && pop_ready;
  assign pop_valid   = (occupancy != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q   <= '0;
      push_credit     <= 1'b0;
      credit_overflow <= 1'b0;
    end else if (push_sender_in_reset) begin
      outstanding_q   <= '0;
      push_credit     <= 1'b0;
      credit_overflow <= 1'b0;
    end else begin
      push_credit   <= issue;
      outstanding_q <= outstanding_eff + CW'(issue) - CW'(push_accept);
      if (push_valid && !push_accept) credit_overflow <= 1'b1;
    end
  end

  credit_receiver_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (push_sender_in_reset),
    .wr_en     (push_accept),
    .wr_data   (push_data),
    .rd_en     (pop_fire),
    .rd_data   (pop_data),
    .occupancy (occupancy),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_credit_receiver_buffered.sv
// Directed bench for credit_receiver_buffered (WIDTH=8, DEPTH=4) with hand-derived credit timelines.
module tb_credit_receiver_buffered;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push_sender_in_reset = 1'b0;
  logic             push_valid = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             push_credit_stall = 1'b0;
  logic [CW-1:0]    credit_initial = '0;
  logic [CW-1:0]    credit_withhold = '0;
  logic             pop_ready = 1'b0;
  logic             push_credit;
  logic             push_receiver_in_reset;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic [CW-1:0]    occupancy;
  logic             credit_overflow;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  credit_receiver_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .push_sender_in_reset   (push_sender_in_reset),
    .push_valid             (push_valid),
    .push_data              (push_data),
    .push_credit_stall      (push_credit_stall),
    .credit_initial         (credit_initial),
    .credit_withhold        (credit_withhold),
    .pop_ready              (pop_ready),
    .push_credit            (push_credit),
    .push_receiver_in_reset (push_receiver_in_reset),
    .pop_valid              (pop_valid),
    .pop_data               (pop_data),
    .occupancy              (occupancy),
    .credit_overflow        (credit_overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset, check reset outputs, release mid-cycle; the next tick is the exit edge.
  task automatic do_reset(input string tag, input logic [CW-1:0] init);
    credit_initial = init;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_credit"}, {31'd0, push_credit}, 32'd0);
    check({tag, "_rst_inrst"}, {31'd0, push_receiver_in_reset}, 32'd1);
    check({tag, "_rst_valid"}, {31'd0, pop_valid}, 32'd0);
    check({tag, "_rst_occ"}, {29'd0, occupancy}, 32'd0);
    check({tag, "_rst_ovf"}, {31'd0, credit_overflow}, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  // Tick n times; bit i of pat is the expected push_credit after tick i.
  task automatic credit_seq(input string tag, input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_c%0d", tag, i), {31'd0, push_credit}, {31'd0, pat[i]});
    end
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  initial begin
    // Test 1: initial 0, no withhold -> four consecutive credits then none.
    do_reset("t1", 3'd0);
    credit_seq("t1", 8, 16'b0000_0000_0000_1111);
    check("t1_inrst", {31'd0, push_receiver_in_reset}, 32'd0);

    // Test 2: fill with initial credits, then drain; credits trail each pop by two edges.
    do_reset("t2", 3'd4);
    credit_seq("t2_exit", 1, 16'd0);
    push_word(8'hA1);
    exp_q.push_back(8'hA1);
    check("t2_lat_valid", {31'd0, pop_valid}, 32'd1);
    check("t2_lat_data", {24'd0, pop_data}, 32'hA1);
    check("t2_c_p1", {31'd0, push_credit}, 32'd0);
    push_word(8'hB2); exp_q.push_back(8'hB2);
    push_word(8'hC3); exp_q.push_back(8'hC3);
    push_word(8'hD4); exp_q.push_back(8'hD4);
    check("t2_full_occ", {29'd0, occupancy}, 32'd4);
    check("t2_full_credit", {31'd0, push_credit}, 32'd0);
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("t2_pop_valid%0d", i), {31'd0, pop_valid}, 32'd1);
      check($sformatf("t2_pop_data%0d", i), {24'd0, pop_data}, {24'd0, e});
      tick();
      check($sformatf("t2_pop_credit%0d", i), {31'd0, push_credit}, (i == 0) ? 32'd0 : 32'd1);
    end
    pop_ready = 1'b0;
    check("t2_empty", {31'd0, pop_valid}, 32'd0);
    credit_seq("t2_tail", 2, 16'b01);

    // Test 3: withhold blocks issue; dropping it releases exactly the remaining two.
    credit_withhold = 3'd2;
    do_reset("t3", 3'd2);
    credit_seq("t3_hold", 3, 16'd0);
    credit_withhold = 3'd0;
    credit_seq("t3_rel", 4, 16'b0011);

    // Test 4: push with zero outstanding is dropped and flags overflow (sticky).
    push_credit_stall = 1'b1;
    do_reset("t4", 3'd0);
    credit_seq("t4_exit", 1, 16'd0);
    push_word(8'h55);
    check("t4_ovf", {31'd0, credit_overflow}, 32'd1);
    check("t4_occ", {29'd0, occupancy}, 32'd0);
    check("t4_valid", {31'd0, pop_valid}, 32'd0);
    push_credit_stall = 1'b0;
    credit_seq("t4_cr", 5, 16'b01111);
    push_word(8'h66);
    check("t4_occ1", {29'd0, occupancy}, 32'd1);
    check("t4_data", {24'd0, pop_data}, 32'h66);
    check("t4_ovf_hold1", {31'd0, credit_overflow}, 32'd1);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    check("t4_occ0", {29'd0, occupancy}, 32'd0);
    check("t4_ovf_hold2", {31'd0, credit_overflow}, 32'd1);

    // Test 5: sender reset with two words stored flushes and reloads credit_initial.
    do_reset("t5", 3'd2);
    credit_seq("t5_init", 3, 16'b011);
    push_word(8'h11);
    push_word(8'h22);
    check("t5_occ2", {29'd0, occupancy}, 32'd2);
    credit_initial = 3'd1;
    push_sender_in_reset = 1'b1;
    push_valid = 1'b1;
    push_data = 8'h33;
    pop_ready = 1'b1;
    tick();
    push_sender_in_reset = 1'b0;
    push_valid = 1'b0;
    pop_ready = 1'b0;
    check("t5_sr_valid", {31'd0, pop_valid}, 32'd0);
    check("t5_sr_occ", {29'd0, occupancy}, 32'd0);
    check("t5_sr_inrst", {31'd0, push_receiver_in_reset}, 32'd1);
    check("t5_sr_credit", {31'd0, push_credit}, 32'd0);
    check("t5_sr_ovf", {31'd0, credit_overflow}, 32'd0);
    tick();
    check("t5_exit_inrst", {31'd0, push_receiver_in_reset}, 32'd0);
    check("t5_exit_credit", {31'd0, push_credit}, 32'd1);
    credit_seq("t5_reload", 3, 16'b011);

    // Test 6: stall suppresses three advertisable credits; release issues them back-to-back.
    push_credit_stall = 1'b1;
    do_reset("t6", 3'd1);
    credit_seq("t6_stall", 3, 16'd0);
    push_credit_stall = 1'b0;
    credit_seq("t6_rel", 4, 16'b0111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
